// File: rtl/alu_cmd_issuer.sv
// Instruction issuer for the combinational 5-bit ALU: buffers packed words in a
// small FIFO, issues one at a time on registered ALU inputs and returns the result.
module alu_cmd_issuer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [12:0]      in_instr,
  output logic [2:0]       alu_opcode,
  output logic [4:0]       alu_a,
  output logic [4:0]       alu_b,
  input  logic [9:0]       alu_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [9:0]       out_result,
  output logic [2:0]       out_opcode,
  output logic             busy,
  output logic [CNT_W-1:0] issue_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_LVL = (PTR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [12:0]      mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W:0]   count_r;
  logic [12:0]      head_s;
  logic             full_s;
  logic             empty_s;
  logic             push_s;
  logic             pop_s;
  logic             capture_s;
  logic             release_s;

  assign full_s   = (count_r == FULL_LVL);
  assign empty_s  = (count_r == '0);
  assign in_ready = !full_s;
  assign push_s   = in_valid && !full_s;
  assign head_s   = mem_r[rd_ptr_r];
  assign busy     = !empty_s || (state_r != ST_IDLE);

  // Next-state and datapath strobes; a pop is only ever issued from IDLE or on a HOLD handshake.
  always_comb begin
    state_nxt_s = state_r;
    pop_s       = 1'b0;
    capture_s   = 1'b0;
    release_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!empty_s) begin
          pop_s       = 1'b1;
          state_nxt_s = ST_EXEC;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_EXEC: begin
        capture_s   = 1'b1;
        state_nxt_s = ST_HOLD;
      end
      ST_HOLD: begin
        if (out_ready) begin
          release_s = 1'b1;
          if (!empty_s) begin
            pop_s       = 1'b1;
            state_nxt_s = ST_EXEC;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end else begin
          state_nxt_s = ST_HOLD;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FIFO storage; contents are meaningless until covered by count_r, so no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= in_instr;
    end
  end

  // FIFO pointers wrap naturally (DEPTH is a power of two); occupancy tracked separately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + (PTR_W + 1)'(1);
        2'b01:   count_r <= count_r - (PTR_W + 1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // ALU operand registers and issue counter; they move only when a word is popped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_opcode  <= 3'd0;
      alu_a       <= 5'd0;
      alu_b       <= 5'd0;
      issue_count <= '0;
    end else if (pop_s) begin
      alu_opcode  <= head_s[12:10];
      alu_a       <= head_s[9:5];
      alu_b       <= head_s[4:0];
      issue_count <= issue_count + CNT_W'(1);
    end
  end

  // Result capture and output handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_result <= 10'd0;
      out_opcode <= 3'd0;
    end else if (capture_s) begin
      out_valid  <= 1'b1;
      out_result <= alu_result;
      out_opcode <= alu_opcode;
    end else if (release_s) begin
      out_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Directed bench for alu_cmd_issuer with a behavioural ALU, an ordered
// scoreboard of expected results and hand-computed literal checks.
module tb_alu_cmd_issuer;

  localparam int DEPTH = 4;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [12:0]      in_instr = 13'd0;
  logic [2:0]       alu_opcode;
  logic [4:0]       alu_a;
  logic [4:0]       alu_b;
  logic [9:0]       alu_result;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [9:0]       out_result;
  logic [2:0]       out_opcode;
  logic             busy;
  logic [CNT_W-1:0] issue_count;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [2:0] op;
    logic [9:0] res;
  } exp_t;

  exp_t       exp_q[$];
  int         hs_total = 0;
  int         hs_base = 0;
  logic       hold_seen = 1'b0;
  logic [9:0] prev_res;
  logic [2:0] prev_op;

  alu_cmd_issuer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_opcode(out_opcode), .busy(busy), .issue_count(issue_count)
  );

  always #5 clk = ~clk;

  // Reference ALU: 6-bit add/sub, 10-bit multiply, bitwise ops, shift by one.
  function automatic logic [9:0] alu_fn(input logic [2:0] op, input logic [4:0] a, input logic [4:0] b);
    logic [5:0] d;
    logic [9:0] r;
    d = 6'd0;
    case (op)
      3'd0: begin d = {1'b0, a} + {1'b0, b}; r = {4'd0, d}; end
      3'd1: begin d = {1'b0, a} - {1'b0, b}; r = {4'd0, d}; end
      3'd2: r = {5'd0, a} * {5'd0, b};
      3'd3: r = {5'd0, a & b};
      3'd4: r = {5'd0, a ^ b};
      3'd5: r = {5'd0, a | b};
      3'd6: r = {4'd0, a, 1'b0};
      default: r = {6'd0, a[4:1]};
    endcase
    return r;
  endfunction

  assign alu_result = alu_fn(alu_opcode, alu_a, alu_b);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare: busy vs outstanding words, ordered results, HOLD stability, push capture.
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      hs_base   = hs_total;
      hold_seen = 1'b0;
    end else begin
      chk("busy", 32'(busy), 32'(exp_q.size() != 0));
      if (out_valid) begin
        if (hold_seen) begin
          chk("hold_result_stable", 32'(out_result), 32'(prev_res));
          chk("hold_opcode_stable", 32'(out_opcode), 32'(prev_op));
        end
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got result %0d with nothing outstanding at %0t", out_result, $time);
        end else if (out_ready) begin
          exp_t e;
          e = exp_q.pop_front();
          chk("sb_result", 32'(out_result), 32'(e.res));
          chk("sb_opcode", 32'(out_opcode), 32'(e.op));
          hs_total++;
          hold_seen = 1'b0;
        end else begin
          hold_seen = 1'b1;
          prev_res  = out_result;
          prev_op   = out_opcode;
        end
      end else begin
        hold_seen = 1'b0;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back('{in_instr[12:10], alu_fn(in_instr[12:10], in_instr[9:5], in_instr[4:0])});
      end
    end
  end

  // All stimulus tasks start and end one time unit after a rising edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [12:0] w, output int waits);
    logic acc;
    waits    = 0;
    in_valid = 1'b1;
    in_instr = w;
    acc      = 1'b0;
    while (!acc && waits < 200) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (!acc) waits++;
    end
    in_valid = 1'b0;
    if (!acc) chk("push_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!out_valid && n < 50) begin
      tick(1);
      n++;
    end
    chk("wait_valid", 32'(out_valid), 32'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 400) begin
      tick(1);
      n++;
    end
    chk("wait_idle", 32'(busy), 32'd0);
  endtask

  task automatic run_one(input string name, input logic [12:0] w, input logic [9:0] lit);
    int wt;
    out_ready = 1'b1;
    push(w, wt);
    wait_valid();
    chk(name, 32'(out_result), 32'(lit));
    chk({name, "_op"}, 32'(out_opcode), 32'(w[12:10]));
    wait_idle();
  endtask

  function automatic logic [CNT_W-1:0] exp_count();
    return CNT_W'(hs_total - hs_base);
  endfunction

  initial begin
    int wt;
    tick(2);
    chk("rst_alu_opcode", 32'(alu_opcode), 32'd0);
    chk("rst_alu_a", 32'(alu_a), 32'd0);
    chk("rst_alu_b", 32'(alu_b), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_result", 32'(out_result), 32'd0);
    chk("rst_out_opcode", 32'(out_opcode), 32'd0);
    chk("rst_issue_count", 32'(issue_count), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    tick(1);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Single add with exact latency: accept E0, issue E1, result valid after E2.
    out_ready = 1'b0;
    push({3'd0, 5'd5, 5'd7}, wt);
    chk("e0_alu_a", 32'(alu_a), 32'd0);
    chk("e0_busy", 32'(busy), 32'd1);
    tick(1);
    chk("e1_alu_a", 32'(alu_a), 32'd5);
    chk("e1_alu_b", 32'(alu_b), 32'd7);
    chk("e1_alu_opcode", 32'(alu_opcode), 32'd0);
    chk("e1_issue_count", 32'(issue_count), 32'd1);
    chk("e1_out_valid", 32'(out_valid), 32'd0);
    tick(1);
    chk("e2_out_valid", 32'(out_valid), 32'd1);
    chk("e2_add_result", 32'(out_result), 32'd12);
    chk("e2_out_opcode", 32'(out_opcode), 32'd0);
    out_ready = 1'b1;
    tick(1);
    chk("e3_out_valid", 32'(out_valid), 32'd0);
    chk("e3_busy", 32'(busy), 32'd0);

    // Result widths through the reference ALU.
    run_one("mul_31x31", {3'd2, 5'd31, 5'd31}, 10'd961);
    run_one("sub_3m5", {3'd1, 5'd3, 5'd5}, 10'd62);
    run_one("half_31", {3'd7, 5'd31, 5'd0}, 10'd15);
    run_one("dbl_31", {3'd6, 5'd31, 5'd0}, 10'd62);
    run_one("add_31p31", {3'd0, 5'd31, 5'd31}, 10'd62);
    run_one("and", {3'd3, 5'b10110, 5'b01100}, 10'd4);
    run_one("xor", {3'd4, 5'b10110, 5'b01100}, 10'd26);
    run_one("or", {3'd5, 5'b10110, 5'b01100}, 10'd30);
    chk("count_after_basic", 32'(issue_count), 32'd9);
    chk("count_model_basic", 32'(issue_count), 32'(exp_count()));

    // Backpressure: one issued plus DEPTH buffered, sixth word stalls until a pop.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      push({3'(i), 5'(i + 1), 5'(2 * i + 3)}, wt);
    end
    chk("full_in_ready", 32'(in_ready), 32'd0);
    fork
      push({3'd2, 5'd9, 5'd9}, wt);
      begin
        tick(3);
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        chk("stall_out_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        tick(1);
        chk("ready_after_pop", 32'(in_ready), 32'd1);
      end
    join
    wait_idle();
    chk("count_model_full", 32'(issue_count), 32'(exp_count()));

    // Streaming with two words queued: one push per two cycles never stalls.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) push({3'(7 - i), 5'(20 + i), 5'(i)}, wt);
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      push({3'(i % 8), 5'(3 * i), 5'(31 - i)}, wt);
      chk("stream_no_stall", 32'(wt), 32'd0);
      tick(1);
    end
    wait_idle();
    chk("count_model_stream", 32'(issue_count), 32'(exp_count()));

    // Reset mid-operation with three words queued and a result pending.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push({3'd0, 5'(i), 5'd1}, wt);
    wait_valid();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_out_result", 32'(out_result), 32'd0);
    chk("mid_rst_issue_count", 32'(issue_count), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_alu_a", 32'(alu_a), 32'd0);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    tick(8);
    chk("post_rst_out_valid", 32'(out_valid), 32'd0);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Counter wrap at 2**CNT_W issues; issuing continues afterwards.
    for (int i = 0; i < 255; i++) push({3'(i % 8), 5'(i % 32), 5'((i * 7) % 32)}, wt);
    wait_idle();
    chk("count_255", 32'(issue_count), 32'd255);
    push({3'd0, 5'd1, 5'd1}, wt);
    wait_idle();
    chk("count_wrap_0", 32'(issue_count), 32'd0);
    run_one("after_wrap_add", {3'd0, 5'd10, 5'd20}, 10'd30);
    chk("count_after_wrap", 32'(issue_count), 32'd1);
    chk("count_model_wrap", 32'(issue_count), 32'(exp_count()));

    tick(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish before 1000000");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/alu_cmd_issuer.md
Name: alu_cmd_issuer

Overview:
- Front-end that feeds the team's combinational 5-bit ALU (alu8inst).
- Accepts packed instruction words over a valid/ready handshake and buffers them in a small FIFO.
- Issues one instruction at a time on registered opcode/operand outputs, then captures the ALU's returned 10-bit result.
- Presents each result with its opcode on a valid/ready output handshake with backpressure.

Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.
- CNT_W, 16, width of issued-instruction counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  instruction word valid.
- in_ready  output  1  FIFO can accept; equals !full.
- in_instr  input  13  {opcode[12:10], a[9:5], b[4:0]}.
- alu_opcode  output  3  to ALU opcode; registered.
- alu_a  output  5  to ALU a; registered.
- alu_b  output  5  to ALU b; registered.
- alu_result  input  10  from ALU result; combinational response to alu_* outputs.
- out_valid  output  1  result available.
- out_ready  input  1  downstream accepts result.
- out_result  output  10  captured ALU result.
- out_opcode  output  3  opcode that produced out_result.
- busy  output  1  FIFO non-empty or state != IDLE.
- issue_count  output  CNT_W  number of instructions issued to the ALU.

Behaviour:
- Reset (rst_n=0, asynchronous): FIFO empty, state IDLE. All of the following are 0: alu_opcode, alu_a, alu_b, out_valid, out_result, out_opcode, issue_count, busy. in_ready=1 after reset release (FIFO empty).
- Opcode encoding, passed through unmodified: 000 add, 001 sub, 010 mul, 011 and, 100 xor, 101 or, 110 a*2, 111 a/2. The issuer does not decode opcodes and does not alter results.
- Push: a word is written on an edge where in_valid && in_ready.
- in_ready depends only on full. There is no same-cycle pass-through when full, even if a pop occurs in that cycle.
- FIFO pointers wrap modulo DEPTH. Occupancy is held in a separate count register so that full and empty are unambiguous.
- FSM states:
  - IDLE: if FIFO non-empty, pop the head into alu_opcode/a/b, increment issue_count, go EXEC. Otherwise stay.
  - EXEC: capture alu_result into out_result and alu_opcode into out_opcode, set out_valid=1, go HOLD. Exactly one cycle.
  - HOLD: out_valid=1 and out_result/out_opcode are stable. On out_valid && out_ready:
    - if FIFO non-empty, pop the next word into the alu_* registers, increment issue_count, clear out_valid, go EXEC;
    - else clear out_valid and go IDLE.
- alu_* registers change only on a pop. Between pops they hold their last value.
- Latency: word accepted at edge E0 → issued at E1 → out_valid=1 after E2. Steady-state throughput with out_ready held at 1 is one result per 2 cycles.
- A push and a pop on the same edge are both honoured; occupancy is unchanged.
- A push while the FIFO is empty and the state is IDLE does not issue in the same cycle; the minimum latency above applies.
- issue_count wraps from all-ones to 0 without a flag.
- out_ready while out_valid=0 is ignored.
- Reset asserted mid-operation aborts everything immediately:
  - queued words are discarded;
  - a pending result is dropped (out_valid=0);
  - nothing is replayed after release.
- busy is registered-equivalent combinational: (count!=0) || (state!=IDLE).

Test Plan:
- Reset then single add: push {000,5'd5,5'd7} → alu_a=5, alu_b=7 one cycle after accept; out_valid after E2 with out_result=10'd12, out_opcode=000; issue_count=1; busy=0 after the handshake.
- Arithmetic widths with a real ALU attached:
  - mul 31*31 → 10'd961;
  - sub 3-5 → 10'd62 (6-bit wrap, upper bits 0);
  - a/2 with a=31 → 10'd15;
  - a*2 with a=31 → 10'd62.
- Backpressure and full FIFO: hold out_ready=0 and push 6 words → first issued, next DEPTH=4 buffered, in_ready=0, 6th word stalls. Release out_ready → results emerge in push order, in_ready returns to 1 on the first pop after full.
- Simultaneous push and pop: keep the FIFO at 2 entries while streaming with out_ready=1 and in_valid=1 → occupancy constant, no loss, no duplication, results in order.
- Reset mid-operation: 3 queued and out_valid=1; pulse rst_n low for a partial cycle → out_valid, out_result and issue_count drop to 0 immediately; no output after release until new pushes.
- Counter wrap: preload a sequence of 65536 issues (or force via bench) → issue_count returns to 0 and issuing continues.
